// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues PC to instruction memory, waits a variable latency,
// and presents the fetched word to IF/ID with stall/flush handling and a sticky timeout flag.
//
// state | meaning
// IDLE  | no fetch outstanding; issue pc_i when allowed
// WAIT  | request outstanding, waiting for mem_ack
// HOLD  | word received while IF/ID frozen; parked in hold buffer
module if_fetch_unit #(
  parameter int unsigned             ADDR_W      = 32,
  parameter int unsigned             DATA_W      = 32,
  parameter logic [7:0]              TIMEOUT_CYC = 8'd255,
  parameter logic [DATA_W-1:0]       NOP_INST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              stall_req,
  output logic              fetch_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              drop_q, drop_d;
  logic              fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;

  logic              load;
  logic [DATA_W-1:0] load_inst;
  logic [ADDR_W-1:0] load_pc;
  logic              unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    wait_cnt_d  = wait_cnt_q;
    drop_d      = drop_q;
    fetch_err_d = fetch_err_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    load        = 1'b0;
    load_inst   = hold_inst_q;
    load_pc     = hold_pc_q;
    stall_req   = 1'b0;

    case (state_q)
      IDLE: begin
        stall_req = ~flush & ~fetch_err_q;
        if (!flush && !fetch_err_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_i;
          wait_cnt_d = '0;
          drop_d     = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // PC may advance exactly in the ack cycle
        stall_req = ~mem_ack;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = IDLE;
          if (!drop_q && !flush) begin
            if (stall[1]) begin
              hold_inst_d = mem_rdata;
              hold_pc_d   = mem_addr_q;
              state_d     = HOLD;
            end else begin
              load      = 1'b1;
              load_inst = mem_rdata;
              load_pc   = mem_addr_q;
            end
          end
        end else if (wait_cnt_q == TIMEOUT_CYC) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
          // memory still owes an ack; remember to throw it away
          if (flush) drop_d = 1'b1;
        end
      end
      HOLD: begin
        stall_req = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (!stall[1]) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (flush) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end else if (load) begin
      if_inst_d  = load_inst;
      if_pc_d    = load_pc;
      if_valid_d = 1'b1;
    end else if (!stall[1]) begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      wait_cnt_q  <= '0;
      drop_q      <= 1'b0;
      fetch_err_q <= 1'b0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      if_inst_q   <= NOP_INST;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      wait_cnt_q  <= wait_cnt_d;
      drop_q      <= drop_d;
      fetch_err_q <= fetch_err_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign if_inst   = if_inst_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table for the normal fetch/flush/stall
// sequence, then hand-written timeout and reset-mid-fetch sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        stall_req;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .stall(stall), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid),
    .stall_req(stall_req), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        st1;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        e_sreq;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic s1, input logic a,
                       input logic [31:0] rd, input logic [31:0] pc);
    flush     = f;
    stall     = {4'b0, s1, 1'b0};
    mem_ack   = a;
    mem_rdata = rd;
    pc_i      = pc;
  endtask

  initial begin
    //         flush st1 ack rdata         pc     | sreq req addr   valid inst          if_pc
    tbl[0]  = '{0, 0, 0, 32'h0,        32'h00,   1, 1, 32'h00, 0, 32'h0,        32'h00};
    tbl[1]  = '{0, 0, 1, 32'h20080005, 32'h00,   0, 0, 32'h00, 1, 32'h20080005, 32'h00};
    tbl[2]  = '{0, 0, 0, 32'h0,        32'h04,   1, 1, 32'h04, 0, 32'h0,        32'h00};
    tbl[3]  = '{0, 0, 0, 32'h0,        32'h04,   1, 1, 32'h04, 0, 32'h0,        32'h00};
    tbl[4]  = '{0, 0, 0, 32'h0,        32'h04,   1, 1, 32'h04, 0, 32'h0,        32'h00};
    tbl[5]  = '{0, 0, 1, 32'h11111111, 32'h04,   0, 0, 32'h04, 1, 32'h11111111, 32'h04};
    tbl[6]  = '{1, 0, 0, 32'h0,        32'h08,   0, 0, 32'h04, 0, 32'h0,        32'h04};
    tbl[7]  = '{0, 0, 0, 32'h0,        32'h08,   1, 1, 32'h08, 0, 32'h0,        32'h04};
    tbl[8]  = '{1, 0, 0, 32'h0,        32'h40,   1, 1, 32'h08, 0, 32'h0,        32'h04};
    tbl[9]  = '{0, 0, 0, 32'h0,        32'h40,   1, 1, 32'h08, 0, 32'h0,        32'h04};
    tbl[10] = '{0, 0, 1, 32'hDEADBEEF, 32'h40,   0, 0, 32'h08, 0, 32'h0,        32'h04};
    tbl[11] = '{0, 0, 0, 32'h0,        32'h40,   1, 1, 32'h40, 0, 32'h0,        32'h04};
    tbl[12] = '{0, 0, 1, 32'h22222222, 32'h40,   0, 0, 32'h40, 1, 32'h22222222, 32'h40};
    tbl[13] = '{0, 1, 0, 32'h0,        32'h44,   1, 1, 32'h44, 1, 32'h22222222, 32'h40};
    tbl[14] = '{0, 1, 1, 32'hAC090004, 32'h44,   0, 0, 32'h44, 1, 32'h22222222, 32'h40};
    tbl[15] = '{0, 1, 0, 32'h0,        32'h44,   1, 0, 32'h44, 1, 32'h22222222, 32'h40};
    tbl[16] = '{0, 0, 0, 32'h0,        32'h44,   1, 0, 32'h44, 1, 32'hAC090004, 32'h44};
    tbl[17] = '{0, 0, 0, 32'h0,        32'h48,   1, 1, 32'h48, 0, 32'h0,        32'h44};
    tbl[18] = '{0, 1, 1, 32'h33333333, 32'h48,   0, 0, 32'h48, 0, 32'h0,        32'h44};
    tbl[19] = '{1, 1, 0, 32'h0,        32'h48,   1, 0, 32'h48, 0, 32'h0,        32'h44};
    tbl[20] = '{0, 0, 0, 32'h0,        32'h4C,   1, 1, 32'h4C, 0, 32'h0,        32'h44};

    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_req",   0, {31'b0, mem_req},   32'h0);
    check("rst_addr",  0, mem_addr,           32'h0);
    check("rst_valid", 0, {31'b0, if_valid},  32'h0);
    check("rst_inst",  0, if_inst,            32'h0);
    check("rst_pc",    0, if_pc,              32'h0);
    check("rst_err",   0, {31'b0, fetch_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].flush, tbl[i].st1, tbl[i].ack, tbl[i].rdata, tbl[i].pc);
      #1;
      check("stall_req", i, {31'b0, stall_req}, {31'b0, tbl[i].e_sreq});
      tick();
      check("mem_req",  i, {31'b0, mem_req},  {31'b0, tbl[i].e_req});
      check("mem_addr", i, mem_addr,          tbl[i].e_addr);
      check("if_valid", i, {31'b0, if_valid}, {31'b0, tbl[i].e_valid});
      check("if_inst",  i, if_inst,           tbl[i].e_inst);
      check("if_pc",    i, if_pc,             tbl[i].e_pc);
    end

    // Timeout: WAIT entered with count 0; 256 ack-less cycles trip the error
    drive(0, 0, 0, 32'h0, 32'h4C);
    for (int i = 0; i < 255; i++) tick();
    check("to_req_pre", 255, {31'b0, mem_req},   32'h1);
    check("to_err_pre", 255, {31'b0, fetch_err}, 32'h0);
    tick();
    check("to_req",     256, {31'b0, mem_req},   32'h0);
    check("to_err",     256, {31'b0, fetch_err}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 32'h0, 32'h100 + 32'(i * 4));
      #1;
      check("err_sreq", i, {31'b0, stall_req}, 32'h0);
      tick();
      check("err_noreq", i, {31'b0, mem_req},  32'h0);
      check("err_stick", i, {31'b0, fetch_err}, 32'h1);
    end

    // Reset clears the error and restores normal issue
    rst = 1'b1;
    tick();
    check("rst2_err", 0, {31'b0, fetch_err}, 32'h0);
    check("rst2_pc",  0, if_pc,              32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h80);
    tick();
    check("rs_req",  0, {31'b0, mem_req}, 32'h1);
    check("rs_addr", 0, mem_addr,         32'h80);
    drive(0, 0, 1, 32'h55, 32'h80);
    tick();
    check("rs_inst",  0, if_inst,           32'h55);
    check("rs_valid", 0, {31'b0, if_valid}, 32'h1);
    drive(0, 1, 0, 32'h0, 32'h84);
    tick();
    check("rs_req2",  0, {31'b0, mem_req}, 32'h1);
    check("rs_hold",  0, if_inst,          32'h55);

    // Reset mid-WAIT, then a stray ack lands while back in IDLE
    rst = 1'b1;
    tick();
    check("mw_req",   0, {31'b0, mem_req},  32'h0);
    check("mw_addr",  0, mem_addr,          32'h0);
    check("mw_valid", 0, {31'b0, if_valid}, 32'h0);
    check("mw_inst",  0, if_inst,           32'h0);
    check("mw_pc",    0, if_pc,             32'h0);
    rst = 1'b0;
    drive(0, 0, 1, 32'hFFFFFFFF, 32'h84);
    tick();
    check("stray_valid", 0, {31'b0, if_valid}, 32'h0);
    check("stray_inst",  0, if_inst,           32'h0);
    check("stray_req",   0, {31'b0, mem_req},  32'h1);
    check("stray_addr",  0, mem_addr,          32'h84);
    drive(0, 0, 0, 32'h0, 32'h84);
    tick();
    check("stray_valid2", 1, {31'b0, if_valid}, 32'h0);
    check("stray_req2",   1, {31'b0, mem_req},  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
